axi4_subordinate_mem: RTL and testbench

AXI4 subordinate endpoint that answers the manager's five channels (AW, W, B, AR, R) and backs them with an internal word-addressed memory. It is the responder for the manager block: it accepts write address and data, commits the data, and returns a write response on B. It accepts read addresses and returns data on R. Single-beat transactions only, with one outstanding transaction per direction. The top address bit acts as the subordinate's chip select.

---
 rtl/axi4_subordinate_mem.sv | 135 +++++++++++++
 tb/tb_axi4_subordinate_mem.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_subordinate_mem.sv
// AXI4 single-beat subordinate backed by a word-addressed memory.
// Top address bit is the chip select; a miss answers DECERR without touching memory.
module axi4_subordinate_mem #(
   parameter int   DATA_W = 8,
   parameter int   ADDR_W = 11,
   parameter logic CS_VAL = 1'b0
) (
   input  logic              aCLK,
   input  logic              ARESET,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              WVALID,
   output logic              WREADY,
   input  logic [DATA_W-1:0] WDATA,
   output logic              BVALID,
   input  logic              BREADY,
   output logic [1:0]        BRESP,
   input  logic              ARVALID,
   output logic              ARREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP
);

   localparam int         IDX_W       = ADDR_W - 1;
   localparam int         DEPTH       = 1 << IDX_W;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // state  | meaning
   // R_IDLE | waiting for AR, ARREADY high
   // R_READ | address latched, memory read on this edge
   // R_RESP | RDATA/RRESP presented until R handshake
   typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              aw_full;
   logic              w_full;
   logic [ADDR_W-1:0] aw_addr;
   logic [DATA_W-1:0] w_data;
   logic              commit;
   logic              commit_ok;

   r_state_t          r_state;
   logic [ADDR_W-1:0] ar_addr;
   logic              ar_ok;

   assign AWREADY   = ~aw_full;
   assign WREADY    = ~w_full;
   assign commit    = aw_full & w_full & ~BVALID;
   assign commit_ok = (aw_addr[ADDR_W-1] == CS_VAL);
   assign ar_ok     = (ar_addr[ADDR_W-1] == CS_VAL);

   always_ff @(posedge aCLK) begin
      if (ARESET) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         aw_addr <= '0;
         w_data  <= '0;
         BVALID  <= 1'b0;
         BRESP   <= RESP_OKAY;
      end else begin
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= commit_ok ? RESP_OKAY : RESP_DECERR;
         end else begin
            // holding registers refill while B is still pending
            if (AWVALID && !aw_full) begin
               aw_addr <= AWADDR;
               aw_full <= 1'b1;
            end
            if (WVALID && !w_full) begin
               w_data <= WDATA;
               w_full <= 1'b1;
            end
            if (BVALID && BREADY) begin
               BVALID <= 1'b0;
               BRESP  <= RESP_OKAY;
            end
         end
      end
   end

   always_ff @(posedge aCLK) begin
      if (!ARESET && commit && commit_ok)
         mem[aw_addr[IDX_W-1:0]] <= w_data;
   end

   always_ff @(posedge aCLK) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         ar_addr <= '0;
         ARREADY <= 1'b1;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ARVALID) begin
                  ar_addr <= ARADDR;
                  ARREADY <= 1'b0;
                  r_state <= R_READ;
               end
            end
            R_READ: begin
               // nonblocking read of mem yields the pre-commit word on a same-edge write
               RDATA   <= ar_ok ? mem[ar_addr[IDX_W-1:0]] : '0;
               RRESP   <= ar_ok ? RESP_OKAY : RESP_DECERR;
               RVALID  <= 1'b1;
               r_state <= R_RESP;
            end
            R_RESP: begin
               if (RREADY) begin
                  RVALID  <= 1'b0;
                  ARREADY <= 1'b1;
                  r_state <= R_IDLE;
               end
            end
            default: begin
               r_state <= R_IDLE;
               ARREADY <= 1'b1;
               RVALID  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_subordinate_mem.sv
// Randomized and directed bench for axi4_subordinate_mem against an array-based memory model.
module tb_axi4_subordinate_mem;

   logic        aCLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [10:0] AWADDR = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [7:0]  WDATA = '0;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [1:0]  BRESP;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [10:0] ARADDR = '0;
   logic        RVALID;
   logic        RREADY = 1'b0;
   logic [7:0]  RDATA;
   logic [1:0]  RRESP;

   int checks = 0;
   int errors = 0;
   logic [7:0] ref_mem [int];

   axi4_subordinate_mem #(.DATA_W(8), .ADDR_W(11), .CS_VAL(1'b0)) dut (
      .aCLK(aCLK), .ARESET(ARESET),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
   );

   always #5 aCLK = ~aCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge aCLK);
      #1;
   endtask

   // Model: chip select is bit 10 == 0; anything else decodes to DECERR and is never stored.
   function automatic logic [1:0] exp_resp(input logic [10:0] a);
      return a[10] ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [7:0] exp_data(input logic [10:0] a);
      if (a[10]) return 8'h00;
      return ref_mem[int'(a[9:0])];
   endfunction

   function automatic void model_write(input logic [10:0] a, input logic [7:0] d);
      if (!a[10]) ref_mem[int'(a[9:0])] = d;
   endfunction

   task automatic do_write(input logic [10:0] a, input logic [7:0] d,
                           output logic [1:0] resp, output int lat, output bit to);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      to = 0; aw_done = 0; w_done = 0; n = 0;
      AWADDR = a; WDATA = d; AWVALID = 1; WVALID = 1; BREADY = 1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         tick();
         if (aw_hs) begin aw_done = 1; AWVALID = 0; end
         if (w_hs)  begin w_done = 1;  WVALID = 0;  end
         n++;
      end
      AWVALID = 0; WVALID = 0;
      lat = 0;
      while (!BVALID && lat < 20) begin tick(); lat++; end
      if (!aw_done || !w_done || !BVALID) to = 1;
      resp = BRESP;
      tick();
   endtask

   task automatic do_read(input logic [10:0] a, output logic [7:0] data,
                          output logic [1:0] resp, output int lat, output bit to);
      bit hs, done;
      int n;
      to = 0; done = 0; n = 0;
      ARADDR = a; ARVALID = 1; RREADY = 1;
      while (!done && n < 20) begin
         hs = ARVALID && ARREADY;
         tick();
         if (hs) begin done = 1; ARVALID = 0; end
         n++;
      end
      ARVALID = 0;
      lat = 0;
      while (!RVALID && lat < 20) begin tick(); lat++; end
      if (!done || !RVALID) to = 1;
      data = RDATA;
      resp = RRESP;
      tick();
   endtask

   task automatic test_reset();
      ARESET = 1;
      repeat (3) tick();
      ARESET = 0;
      tick();
      checks++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready got %b want 1", AWREADY); end
      checks++; if (WREADY !== 1'b1) begin errors++; $display("FAIL reset_wready got %b want 1", WREADY); end
      checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL reset_arready got %b want 1", ARREADY); end
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b want 0", BVALID); end
      checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", RVALID); end
      checks++; if (BRESP !== 2'b00) begin errors++; $display("FAIL reset_bresp got %b want 00", BRESP); end
      checks++; if (RRESP !== 2'b00) begin errors++; $display("FAIL reset_rresp got %b want 00", RRESP); end
      checks++; if (RDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", RDATA); end
   endtask

   task automatic test_basic();
      logic [1:0] resp; logic [7:0] data; int lat; bit to;
      do_write(11'h005, 8'hA5, resp, lat, to);
      model_write(11'h005, 8'hA5);
      checks++; if (to || lat !== 1) begin errors++; $display("FAIL basic_b_latency got %0d to=%0d want 1", lat, to); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b want 00", resp); end
      do_read(11'h005, data, resp, lat, to);
      checks++; if (to || lat !== 1) begin errors++; $display("FAIL basic_r_latency got %0d to=%0d want 1", lat, to); end
      checks++; if (data !== exp_data(11'h005)) begin errors++; $display("FAIL basic_rdata got %h want %h", data, exp_data(11'h005)); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL basic_rresp got %b want 00", resp); end
   endtask

   task automatic test_split_order();
      logic [1:0] resp; logic [7:0] data; int lat; bit to;
      BREADY = 1;
      WDATA = 8'h3C; WVALID = 1;
      tick();
      WVALID = 0;
      checks++; if (WREADY !== 1'b0) begin errors++; $display("FAIL split_wready got %b want 0", WREADY); end
      tick(); tick();
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL split_early_b got %b want 0", BVALID); end
      AWADDR = 11'h010; AWVALID = 1;
      tick();
      AWVALID = 0;
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL split_b_same_edge got %b want 0", BVALID); end
      tick();
      checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL split_b got v=%b r=%b want v=1 r=00", BVALID, BRESP); end
      tick();
      model_write(11'h010, 8'h3C);
      do_read(11'h010, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h010)) begin errors++; $display("FAIL split_rdata got %h want %h", data, exp_data(11'h010)); end
   endtask

   task automatic test_decerr();
      logic [1:0] resp; logic [7:0] data; int lat; bit to;
      do_write(11'h405, 8'hFF, resp, lat, to);
      model_write(11'h405, 8'hFF);
      checks++; if (to || resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp got %b want 11", resp); end
      do_read(11'h405, data, resp, lat, to);
      checks++; if (to || resp !== 2'b11) begin errors++; $display("FAIL decerr_rresp got %b want 11", resp); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL decerr_rdata got %h want 00", data); end
      do_read(11'h005, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h005)) begin errors++; $display("FAIL decerr_alias got %h want %h", data, exp_data(11'h005)); end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; logic [7:0] data; int lat; bit to, aw_hs, w_hs;
      AWADDR = 11'h030; WDATA = 8'h5A; AWVALID = 1; WVALID = 1; BREADY = 0;
      tick();
      AWADDR = 11'h031; WDATA = 8'h6B;
      for (int i = 0; i < 6; i++) begin
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         tick();
         if (aw_hs) AWVALID = 0;
         if (w_hs)  WVALID = 0;
         checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL bp_b_hold cyc %0d got v=%b r=%b want v=1 r=00", i, BVALID, BRESP); end
      end
      AWVALID = 0; WVALID = 0;
      checks++; if ({AWREADY, WREADY} !== 2'b00) begin errors++; $display("FAIL bp_second_latched got %b want 00", {AWREADY, WREADY}); end
      BREADY = 1;
      tick();
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL bp_b_drop got %b want 0", BVALID); end
      tick();
      checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL bp_second_b got v=%b r=%b want v=1 r=00", BVALID, BRESP); end
      tick();
      model_write(11'h030, 8'h5A);
      model_write(11'h031, 8'h6B);
      do_read(11'h030, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h030)) begin errors++; $display("FAIL bp_first_data got %h want %h", data, exp_data(11'h030)); end
      ARADDR = 11'h031; ARVALID = 1; RREADY = 0;
      tick();
      ARVALID = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if (RVALID !== 1'b1 || RDATA !== exp_data(11'h031) || ARREADY !== 1'b0) begin
            errors++; $display("FAIL bp_r_hold cyc %0d got v=%b d=%h ar=%b want v=1 d=%h ar=0", i, RVALID, RDATA, ARREADY, exp_data(11'h031));
         end
         tick();
      end
      RREADY = 1;
      tick();
      checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin errors++; $display("FAIL bp_r_release got v=%b ar=%b want v=0 ar=1", RVALID, ARREADY); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bb [4];
      logic [1:0] resp; logic [7:0] data; int lat; bit to, aw_hs, w_hs;
      int kaw, kw, nb, t, last;
      for (int i = 0; i < 4; i++) bb[i] = 8'($urandom);
      kaw = 0; kw = 0; nb = 0; t = 0; last = 0;
      AWADDR = 11'h200; WDATA = bb[0]; AWVALID = 1; WVALID = 1; BREADY = 1;
      while (nb < 4 && t < 30) begin
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         tick();
         t++;
         if (aw_hs) begin kaw++; if (kaw < 4) AWADDR = 11'h200 + 11'(kaw); else AWVALID = 0; end
         if (w_hs)  begin kw++;  if (kw < 4) WDATA = bb[kw]; else WVALID = 0; end
         if (BVALID) begin
            if (nb > 0) begin
               checks++; if (t - last !== 2) begin errors++; $display("FAIL b2b_spacing write %0d got %0d want 2", nb, t - last); end
            end
            checks++; if (BRESP !== 2'b00) begin errors++; $display("FAIL b2b_bresp write %0d got %b want 00", nb, BRESP); end
            last = t;
            model_write(11'h200 + 11'(nb), bb[nb]);
            nb++;
         end
      end
      AWVALID = 0; WVALID = 0;
      checks++; if (nb !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", nb); end
      tick();
      do_read(11'h203, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h203)) begin errors++; $display("FAIL b2b_readback got %h want %h", data, exp_data(11'h203)); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] resp; logic [7:0] data; int lat; bit to;
      do_write(11'h020, 8'h11, resp, lat, to);
      model_write(11'h020, 8'h11);
      AWADDR = 11'h020; WDATA = 8'h77; AWVALID = 1; WVALID = 1;
      ARADDR = 11'h020; ARVALID = 1; BREADY = 1; RREADY = 1;
      tick();
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      tick();
      checks++; if (RVALID !== 1'b1 || RDATA !== 8'h11) begin errors++; $display("FAIL simul_old_word got v=%b d=%h want v=1 d=11", RVALID, RDATA); end
      checks++; if (BVALID !== 1'b1) begin errors++; $display("FAIL simul_commit got %b want 1", BVALID); end
      tick();
      model_write(11'h020, 8'h77);
      do_read(11'h020, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h020)) begin errors++; $display("FAIL simul_new_word got %h want %h", data, exp_data(11'h020)); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [7:0] data; int lat; bit to;
      AWADDR = 11'h040; WDATA = 8'h99; AWVALID = 1; WVALID = 1;
      ARADDR = 11'h005; ARVALID = 1; BREADY = 0; RREADY = 0;
      tick();
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      tick();
      checks++; if ({BVALID, RVALID} !== 2'b11) begin errors++; $display("FAIL rstmid_setup got %b want 11", {BVALID, RVALID}); end
      model_write(11'h040, 8'h99);
      ARESET = 1;
      tick();
      ARESET = 0;
      checks++; if ({BVALID, RVALID} !== 2'b00) begin errors++; $display("FAIL rstmid_valids got %b want 00", {BVALID, RVALID}); end
      checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL rstmid_readys got %b want 111", {AWREADY, WREADY, ARREADY}); end
      checks++; if (RDATA !== 8'h00 || RRESP !== 2'b00 || BRESP !== 2'b00) begin errors++; $display("FAIL rstmid_payload got d=%h rr=%b br=%b want 00/00/00", RDATA, RRESP, BRESP); end
      BREADY = 1;
      AWADDR = 11'h005; WDATA = 8'hEE; AWVALID = 1; WVALID = 1;
      tick();
      AWVALID = 0; WVALID = 0;
      ARESET = 1;
      tick();
      ARESET = 0;
      checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL rstmid_commit_b got %b want 0", BVALID); end
      tick();
      do_read(11'h005, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h005)) begin errors++; $display("FAIL rstmid_mem_kept got %h want %h", data, exp_data(11'h005)); end
      do_read(11'h040, data, resp, lat, to);
      checks++; if (to || data !== exp_data(11'h040)) begin errors++; $display("FAIL rstmid_prior_write got %h want %h", data, exp_data(11'h040)); end
   endtask

   task automatic test_random();
      logic [1:0] resp; logic [7:0] data, d; logic [10:0] a; int lat; bit to;
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         a = 11'h100 + 11'(i);
         do_write(a, d, resp, lat, to);
         model_write(a, d);
         checks++; if (to || resp !== 2'b00) begin errors++; $display("FAIL rand_fill idx %0d got %b want 00", i, resp); end
      end
      for (int i = 0; i < 40; i++) begin
         a = 11'h100 + 11'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) a[10] = 1'b1;
         if ($urandom_range(0, 1) == 0) begin
            d = 8'($urandom);
            do_write(a, d, resp, lat, to);
            model_write(a, d);
            checks++; if (to || lat !== 1 || resp !== exp_resp(a)) begin
               errors++; $display("FAIL rand_write addr %h got r=%b lat=%0d want r=%b lat=1", a, resp, lat, exp_resp(a));
            end
         end else begin
            do_read(a, data, resp, lat, to);
            checks++; if (to || lat !== 1 || resp !== exp_resp(a) || data !== exp_data(a)) begin
               errors++; $display("FAIL rand_read addr %h got d=%h r=%b lat=%0d want d=%h r=%b lat=1", a, data, resp, lat, exp_data(a), exp_resp(a));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_split_order();
      test_decerr();
      test_backpressure();
      test_back_to_back();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
